// File: rtl/sseg_pkg.sv
// Shared constants and types for the multiplexed seven-segment scan driver.
package sseg_pkg;

  localparam logic [7:0] SEG_OFF  = 8'hFF;
  localparam logic [7:0] SEG_ZERO = 8'h81;
  localparam logic [3:0] AN_OFF   = 4'b1111;

  typedef logic [1:0] digit_idx_t;

  // Active-low one-hot anode pattern for a digit index.
  function automatic logic [3:0] an_select(input digit_idx_t idx);
    logic [3:0] an_v;
    case (idx)
      2'd0:    an_v = 4'b1110;
      2'd1:    an_v = 4'b1101;
      2'd2:    an_v = 4'b1011;
      2'd3:    an_v = 4'b0111;
      default: an_v = AN_OFF;
    endcase
    return an_v;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler counting 0..DIV-1; tick_o marks the wrap cycle.
module tick_gen #(
  parameter int unsigned DIV = 100000,
  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [CW-1:0] cnt_o,
  output logic          tick_o
);

  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next prescaler value with wrap at the divisor.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Prescaler state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/sseg_scan_driver.sv
// Four-digit multiplexed seven-segment driver with frame-synchronous loading,
// leading-zero suppression and whole-display blink.
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned BLINK_TICKS  = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] seg_word,
  input  logic        load,
  input  logic        lz_blank,
  input  logic        blink_en,
  output logic [3:0]  an,
  output logic [7:0]  seg,
  output logic        frame_done
);

  localparam int unsigned PW = $clog2(REFRESH_DIV);
  localparam int unsigned BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [PW-1:0] BLANK_LIM  = PW'(BLANK_CYCLES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  logic [PW-1:0] pre_cnt_s;
  logic          slot_tick_s;
  logic          frame_tick_s;

  digit_idx_t    idx_q,       idx_d;
  logic [31:0]   shadow_q,    shadow_d;
  logic [31:0]   disp_q,      disp_d;
  logic          pend_q,      pend_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q,     phase_d;
  logic [3:0]    an_q,        an_d;
  logic [7:0]    seg_q,       seg_d;
  logic          frame_q,     frame_d;

  logic [3:0]    zsup_s;
  logic [7:0]    cur_byte_s;
  logic          lit_s;

  tick_gen #(.DIV(REFRESH_DIV)) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .cnt_o  (pre_cnt_s),
    .tick_o (slot_tick_s)
  );

  assign frame_tick_s = slot_tick_s && (idx_q == 2'd3);

  // Digit index, load shadowing and frame-boundary display update.
  always_comb begin
    idx_d    = idx_q;
    shadow_d = shadow_q;
    disp_d   = disp_q;
    pend_d   = pend_q;
    if (slot_tick_s) begin
      idx_d = idx_q + 2'd1;
    end else begin
      idx_d = idx_q;
    end
    if (load) begin
      shadow_d = seg_word;
      pend_d   = 1'b1;
    end else begin
      shadow_d = shadow_q;
    end
    // The display only changes here so a frame is never torn.
    if (frame_tick_s) begin
      pend_d = 1'b0;
      if (load) begin
        disp_d = seg_word;
      end else if (pend_q) begin
        disp_d = shadow_q;
      end else begin
        disp_d = disp_q;
      end
    end else begin
      disp_d = disp_q;
    end
  end

  // Blink phase toggles every BLINK_TICKS slot ticks, independent of blink_en.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (slot_tick_s) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end else begin
      blink_cnt_d = blink_cnt_q;
    end
  end

  // Output selection: guard band, blink and leading-zero suppression.
  always_comb begin
    zsup_s[0] = 1'b0;
    zsup_s[3] = lz_blank && (disp_q[31:24] == SEG_ZERO);
    zsup_s[2] = zsup_s[3] && (disp_q[23:16] == SEG_ZERO);
    zsup_s[1] = zsup_s[2] && (disp_q[15:8] == SEG_ZERO);
    case (idx_q)
      2'd0:    cur_byte_s = disp_q[7:0];
      2'd1:    cur_byte_s = disp_q[15:8];
      2'd2:    cur_byte_s = disp_q[23:16];
      2'd3:    cur_byte_s = disp_q[31:24];
      default: cur_byte_s = SEG_OFF;
    endcase
    lit_s = (pre_cnt_s >= BLANK_LIM) && !(blink_en && !phase_q) && !zsup_s[idx_q];
    if (lit_s) begin
      an_d  = an_select(idx_q);
      seg_d = cur_byte_s;
    end else begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
    end
    frame_d = frame_tick_s;
  end

  // State and registered-output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= 2'd0;
      shadow_q    <= 32'hFFFF_FFFF;
      disp_q      <= 32'hFFFF_FFFF;
      pend_q      <= 1'b0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      an_q        <= AN_OFF;
      seg_q       <= SEG_OFF;
      frame_q     <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      disp_q      <= disp_d;
      pend_q      <= pend_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      frame_q     <= frame_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = frame_q;

endmodule

// File: doc/sseg_scan_driver.md
SSEG_SCAN_DRIVER -- requirements
Module: sseg_scan_driver

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clock cycles each digit is driven (1 kHz per digit at 100 MHz); SHALL be >= 4.
REQ-002 Parameter BLANK_CYCLES, default 16, anode-off guard cycles at the start of each digit slot; SHALL be < REFRESH_DIV.
REQ-003 Parameter BLINK_TICKS, default 256, digit slots per blink half-period; SHALL be >= 1.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 seg_word  input  32  four active-low segment bytes; [31:24] is digit 3 (leftmost), [7:0] is digit 0 (rightmost); per byte [7:1]=g..a, [0]=dp.
REQ-007 load  input  1  capture strobe for seg_word, sampled every clk.
REQ-008 lz_blank  input  1  leading-zero suppression enable.
REQ-009 blink_en  input  1  whole-display blink enable.
REQ-010 an  output  4  active-low anode enables, an[i] drives digit i.
REQ-011 seg  output  8  active-low cathodes, same bit order as one seg_word byte.
REQ-012 frame_done  output  1  one-cycle pulse at each frame boundary.

Function
REQ-013 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap; its wrap is the slot tick.
REQ-014 Digit index (2 bits) SHALL advance 0->1->2->3->0 on each slot tick.
REQ-015 Frame boundary SHALL be the slot tick on which the index wraps 3->0; frame_done SHALL pulse high for exactly that cycle.
REQ-016 load=1 SHALL write seg_word into a shadow register and set pending.
REQ-017 At a frame boundary the display register SHALL take seg_word if load=1 that cycle, else the shadow if pending=1, else hold; pending SHALL then clear.
REQ-018 Display content SHALL never change mid-frame (no tearing).
REQ-019 Digit i SHALL be lit (an[i]=0, all other an bits 1) only when the prescaler is >= BLANK_CYCLES, it is not blink-suppressed, and it is not zero-suppressed; otherwise an=4'b1111.
REQ-020 seg SHALL present the display byte for the current digit while lit, else 8'hFF.
REQ-021 an and seg SHALL be registered: one cycle of latency from prescaler/index state.
REQ-022 Zero suppression: with lz_blank=1, digits 3, 2, 1 whose byte equals 8'h81 (zero, dp off) SHALL be blanked while all more-significant digits are also 8'h81; digit 0 SHALL never be blanked.
REQ-023 A zero byte with the dp on (8'h80) SHALL count as nonzero and SHALL stop suppression.
REQ-024 Blink: a counter SHALL count slot ticks and toggle a phase bit every BLINK_TICKS ticks; blink_en=1 with phase=0 SHALL force an=4'b1111.
REQ-025 The blink counter SHALL run regardless of blink_en; deasserting blink_en SHALL take effect at the next output register update.
REQ-026 lz_blank and blink_en SHALL be evaluated every cycle (not frame-latched).

Reset
REQ-027 rst_n low SHALL asynchronously set: prescaler 0, index 0, shadow and display 32'hFFFFFFFF, pending 0, blink counter 0, phase 1, an 4'b1111, seg 8'hFF, frame_done 0.
REQ-028 Reset mid-frame SHALL discard any pending load; after release, the first frame boundary SHALL occur 4*REFRESH_DIV cycles later.

Structure
REQ-029 Shared package sseg_pkg SHALL hold SEG_OFF=8'hFF, SEG_ZERO=8'h81, AN_OFF=4'b1111 and the 2-bit digit-index type.
REQ-030 The prescaler plus slot tick SHALL be one sub-module, tick_gen, parameterised by divisor; all other logic stays in sseg_scan_driver.

Verification (REFRESH_DIV=8, BLANK_CYCLES=2, BLINK_TICKS=2)
REQ-031 Reset, then load 32'h81F34961 ("0123") -> after the first boundary, an cycles 1110,1101,1011,0111 with seg 61,49,F3,81; each slot shows 2 cycles of an=1111 first.
REQ-032 lz_blank=1 with word 81818161 -> only digit 0 lit (seg 61); word 81808161 -> digits 2..0 lit, digit 3 blanked.
REQ-033 load pulsed mid-frame with a new word -> old word held until the boundary, new word shown from the next frame; load on the boundary cycle -> that word shown immediately.
REQ-034 blink_en=1 -> an=1111 for 2 slots (16 cycles), lit for the next 2 slots, repeating.
REQ-035 rst_n asserted mid-slot -> an=1111 and seg=FF in the same cycle; frame_done first pulses 32 cycles after release.
